dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DMEM_BASE, default 32'h10010000, byte address of data RAM.
REQ-002 Parameter DMEM_WORDS, default 1024, RAM depth in 32-bit words (power of two).
REQ-003 Parameter MMIO_BASE, default 32'hFFFF0000, byte address of MMIO register block.
REQ-004 Parameter TX_DEPTH, default 8, console FIFO depth (power of two, 2..16).
REQ-005 CLK  in  1  sole clock; all state updates on rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 MemRead  in  1  core read strobe (M stage).
REQ-008 MemWrite  in  4  byte-lane write enables; bit i = byte lane i.
REQ-009 Addr  in  32  byte address (core ComputeResultM).
REQ-010 WriteData  in  32  lane-aligned store data.
REQ-011 ReadData  out  32  word read data, combinational from Addr, valid in the same cycle.
REQ-012 tx_data  out  8  console byte at FIFO head.
REQ-013 tx_valid  out  1  FIFO non-empty.
REQ-014 tx_ready  in  1  sink accepts tx_data when tx_valid & tx_ready.
REQ-015 led  out  16  LED register bits [15:0].
REQ-016 bus_err  out  1  sticky unmapped-access flag.

Function
REQ-017 Decode SHALL use Addr[31:2]; Addr[1:0] ignored; reads return whole word (core extracts bytes).
REQ-018 DMEM hit: Addr in [DMEM_BASE, DMEM_BASE+4*DMEM_WORDS); each enabled lane written at clock edge; read asynchronous.
REQ-019 MMIO map (offset from MMIO_BASE): 0x0 TXDATA, 0x4 STATUS, 0x8 LED, 0xC CYCLE; other offsets unmapped.
REQ-020 TXDATA write with MemWrite[0]=1 pushes WriteData[7:0]; MemWrite[0]=0 pushes nothing; TXDATA reads 0.
REQ-021 STATUS read = {24'b0, count[3:0], 1'b0, overflow, full, empty}; write with MemWrite[0] and WriteData[2]=1 clears overflow (W1C).
REQ-022 LED read = {16'b0, led}; write updates lane 0/1 bytes per MemWrite[1:0]; lanes 2/3 ignored.
REQ-023 CYCLE: 32-bit counter, +1 every cycle, wraps FFFFFFFF->0; any write lane clears to 0, write beats increment; reads show pre-edge value.
REQ-024 FIFO pop when tx_valid & tx_ready; head advances next cycle; tx_data stable while tx_valid & !tx_ready.
REQ-025 Push when full and no pop in same cycle: byte dropped, overflow set to 1.
REQ-026 Simultaneous push and pop: both occur, count unchanged, legal even when full.
REQ-027 Push into empty FIFO: tx_valid=1 the following cycle (no bypass).
REQ-028 Unmapped access with MemRead=1 or MemWrite!=0: ReadData=0, no state change, bus_err set next cycle and held until reset.
REQ-029 MemRead=0 and MemWrite=0: no state change; ReadData still reflects decode (no side effects on read).

Reset
REQ-030 On RESET: FIFO empty (tx_valid=0, count=0), overflow=0, led=0, CYCLE=0, bus_err=0; RAM contents not reset.
REQ-031 RESET mid-transfer SHALL discard queued bytes and any same-cycle write; RESET dominates all updates.

Structure
REQ-032 Address map offsets, STATUS bit positions and region bases SHALL live in shared header mem_map.vh, also used by the top-level and testbench.
REQ-033 FIFO SHALL be sub-module tx_fifo (push/pop/full/empty/count, synchronous reset); register decode and RAM stay in dmem_responder.

Verification
REQ-034 SW word 0xDEADBEEF to 0x10010004, then SB 0x55 lane 2 (MemWrite=4'b0100, WriteData=0x00550000) -> read 0x10010004 returns 0xDE55BEEF.
REQ-035 Write 'A','B','C' to TXDATA with tx_ready=0 -> STATUS=0x30; raise tx_ready -> tx_data 0x41,0x42,0x43 on consecutive cycles, then tx_valid=0.
REQ-036 Nine pushes with tx_ready=0 (TX_DEPTH=8) -> STATUS=0x86 (count 8, overflow, full); W1C 0x4 -> STATUS=0x82; ninth byte never emitted.
REQ-037 Full FIFO, tx_ready=1, push same cycle -> count stays 8, overflow stays 0, pushed byte emitted last.
REQ-038 Write CYCLE at cycle N, read 5 cycles later -> 4; read at 0xFFFF0010 -> ReadData 0, bus_err=1 next cycle, led unchanged.
REQ-039 Assert RESET with 3 bytes queued and led=0x00FF -> next cycle tx_valid=0, led=0, CYCLE=0, bus_err=0.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared address map and STATUS word packing
package dmem_responder_pkg;
`include "mem_map.vh"

  // Builds the STATUS read word from the FIFO flags using the shared bit positions.
  function automatic logic [31:0] pack_status(input logic [3:0] count, input logic overflow,
                                              input logic full, input logic empty);
    logic [31:0] s;
    s = '0;
    s[STATUS_COUNT_LSB +: 4] = count;
    s[STATUS_OVF_BIT]        = overflow;
    s[STATUS_FULL_BIT]       = full;
    s[STATUS_EMPTY_BIT]      = empty;
    return s;
  endfunction
endpackage

// File: rtl/mem_map.vh
// rtl/mem_map.vh - region bases, MMIO register offsets and STATUS bit positions
`ifndef MEM_MAP_VH
`define MEM_MAP_VH
localparam logic [31:0] MAP_DMEM_BASE = 32'h1001_0000;
localparam logic [31:0] MAP_MMIO_BASE = 32'hFFFF_0000;
localparam logic [3:0]  MMIO_TXDATA   = 4'h0;
localparam logic [3:0]  MMIO_STATUS   = 4'h4;
localparam logic [3:0]  MMIO_LED      = 4'h8;
localparam logic [3:0]  MMIO_CYCLE    = 4'hC;
localparam int STATUS_EMPTY_BIT = 0;
localparam int STATUS_FULL_BIT  = 1;
localparam int STATUS_OVF_BIT   = 2;
localparam int STATUS_COUNT_LSB = 4;
`endif

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - console byte FIFO with push/pop, count and synchronous reset
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]    slots [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok, push_ok;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = slots[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is legal alongside it.
  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (push_ok && !pop_ok) count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  // Pointer/count registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Byte storage, not reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) slots[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data RAM plus console/LED/cycle MMIO responder for the core M stage
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = MAP_DMEM_BASE,
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE  = MAP_MMIO_BASE,
  parameter int          TX_DEPTH   = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MemRead,
  input  logic [3:0]  MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] led,
  output logic        bus_err
);
  localparam int AW = $clog2(DMEM_WORDS);
  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [31:0]   mem [DMEM_WORDS];
  logic [29:0]   dmem_off;
  logic [AW-1:0] dmem_idx;
  logic          dmem_hit, mmio_hit, access;
  logic          sel_tx, sel_status, sel_led, sel_cycle;
  logic          unused_addr_bits;

  logic [15:0]   led_q, led_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   cycle_q, cycle_d;
  logic          bus_err_q, bus_err_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  assign unused_addr_bits = ^Addr[1:0];

  // Word-granular decode; an address below DMEM_BASE wraps to a large offset and misses.
  always_comb begin
    dmem_off   = Addr[31:2] - DMEM_BASE[31:2];
    dmem_idx   = dmem_off[AW-1:0];
    dmem_hit   = (dmem_off < 30'(DMEM_WORDS));
    mmio_hit   = !dmem_hit && (Addr[31:4] == MMIO_BASE[31:4]);
    access     = MemRead | (|MemWrite);
    sel_tx     = mmio_hit && (Addr[3:2] == MMIO_TXDATA[3:2]);
    sel_status = mmio_hit && (Addr[3:2] == MMIO_STATUS[3:2]);
    sel_led    = mmio_hit && (Addr[3:2] == MMIO_LED[3:2]);
    sel_cycle  = mmio_hit && (Addr[3:2] == MMIO_CYCLE[3:2]);
  end

  // Read mux is purely combinational so reads never have side effects.
  always_comb begin
    ReadData = '0;
    if (dmem_hit) ReadData = mem[dmem_idx];
    else if (sel_status) ReadData = pack_status(4'(fifo_count), overflow_q, fifo_full, fifo_empty);
    else if (sel_led) ReadData = {16'b0, led_q};
    else if (sel_cycle) ReadData = cycle_q;
  end

  // Register next-state: CYCLE free-runs unless written, overflow is set on a dropped push.
  always_comb begin
    led_d      = led_q;
    overflow_d = overflow_q;
    cycle_d    = cycle_q + 32'd1;
    bus_err_d  = bus_err_q;
    fifo_push  = sel_tx & MemWrite[0];
    fifo_pop   = ~fifo_empty & tx_ready;
    if (access && !dmem_hit && !mmio_hit) bus_err_d = 1'b1;
    if (sel_status && MemWrite[0] && WriteData[STATUS_OVF_BIT]) overflow_d = 1'b0;
    if (sel_led && MemWrite[0]) led_d[7:0] = WriteData[7:0];
    if (sel_led && MemWrite[1]) led_d[15:8] = WriteData[15:8];
    if (sel_cycle && (|MemWrite)) cycle_d = '0;
    if (fifo_push && fifo_full && !fifo_pop) overflow_d = 1'b1;
  end

  // Control registers; reset overrides every same-cycle update.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      led_q      <= '0;
      overflow_q <= 1'b0;
      cycle_q    <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      led_q      <= led_d;
      overflow_q <= overflow_d;
      cycle_q    <= cycle_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Byte-lane RAM writes; contents survive reset but a write during reset is discarded.
  always_ff @(posedge CLK) begin
    if (!RESET && dmem_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (MemWrite[i]) mem[dmem_idx][8*i +: 8] <= WriteData[8*i +: 8];
      end
    end
  end

  tx_fifo #(
    .DEPTH (TX_DEPTH),
    .CW    (CW)
  ) u_tx_fifo (
    .clk       (CLK),
    .reset     (RESET),
    .push      (fifo_push),
    .push_data (WriteData[7:0]),
    .pop       (fifo_pop),
    .head_data (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign tx_valid = ~fifo_empty;
  assign led      = led_q;
  assign bus_err  = bus_err_q;
endmodule
